pos_decode_unit: RTL
====================

Name: pos_decode_unit

Overview:
- Multi-cycle inverse of the DIFF position encoder in the miniRISC ALU path. Takes a bit-position code (0 = none, 1..32 = bit index + 1) and produces the 32-bit mask it denotes: one-hot or thermometer (all bits below and at the position).
- Sits beside the ALU as a start/done coprocessor. The control FSM issues `start` and stalls on `busy` until `done`.
- Mask is built iteratively, one shift per cycle. No wide decoder.

Parameters:
- WIDTH, 32, data/mask width. Legal codes are 0..WIDTH.
- CNT_W, 6, width of the internal down-counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset. Sampled on the rising edge of `clk`.
- start  in  1  request. Accepted only in IDLE.
- code  in  32  position code. Sampled on the accepting edge.
- mode  in  1  0 = one-hot, 1 = thermometer. Sampled on the accepting edge.
- busy  out  1  high in SHIFT state.
- done  out  1  one-cycle pulse when `out` becomes valid.
- err  out  1  high with `done` when `code` > WIDTH. Held until next accept.
- out  out  32  result mask. Held until the next accepted `start`.

Behaviour:
- Reset (`rst`=1 at an edge):
  - state=IDLE, `out`=0, `done`=0, `err`=0, `busy`=0, counter=0, mask=0.
  - Reset mid-SHIFT aborts the operation. No `done` is produced.
- States:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1.
  - `done` is a registered pulse, asserted in the cycle after the finishing edge. State is IDLE during that cycle.
- IDLE, `start`=1 at edge E0:
  - `out`<=0 and `err`<=0. The previous result is cleared.
  - code==0: `out`<=0, `done`<=1, stay IDLE. Latency 1.
  - code>WIDTH: `out`<=0, `err`<=1, `done`<=1, stay IDLE. Latency 1.
  - 1<=code<=WIDTH: mask<=1, counter<=code-1, latch `mode`, go SHIFT.
- SHIFT, at each edge:
  - counter==0: `out`<=mask, `done`<=1, go IDLE.
  - Otherwise, mode 0: mask<={mask[WIDTH-2:0],1'b0}.
  - Otherwise, mode 1: mask<={mask[WIDTH-2:0],1'b1}.
  - In both shift cases: counter<=counter-1.
- Latency: `done` is visible in the cycle after edge E(code). For example, code=1 gives `done` after E1; code=32 gives `done` after E32.
- `start` while `busy`: ignored. `code` and `mode` changes during SHIFT have no effect.
- `start` in the `done` cycle: legal. Accepted at the next edge, which also drops `done` (the pulse is not extended).
- Width rule:
  - Only the low CNT_W bits are loaded into the counter, and only after the range check.
  - The range check uses all 32 bits of `code`.
- No wrap-around: the shift count never exceeds WIDTH-1, so bit WIDTH-1 is the highest bit ever set.
- Invariant: `out` equals the input that the DIFF encoder maps back to `code`, for mode 0 and codes 0..32.

Decomposition:
- Shared package `pos_decode_pkg`:
  - state enum IDLE/SHIFT.
  - MODE_ONEHOT=1'b0, MODE_THERMO=1'b1.
  - POS_NONE=0, POS_MAX=32.
- One natural sub-module, `pos_shift_mask`: WIDTH-bit shift register with load-to-1 and fill-bit input (0/1). The top level keeps the FSM, counter, range check and output registers.

Test Plan:
- Reset then idle, and reset mid-operation:
  - Assert `rst` 2 cycles → `out`=0, `done`=0, `busy`=0, `err`=0.
  - Start code=20, assert `rst` at cycle 5 → `busy`=0 next cycle, no `done` pulse ever.
- One-hot sweep, mode 0: code=k for k=1..32 → `done` exactly k cycles after the accept edge, `out`=1<<(k-1), `err`=0. For example, code=32 gives `out`=0x80000000 after 32 cycles.
- Thermometer, mode 1: code=5 → `out`=0x0000001F after 5 cycles; code=32 → `out`=0xFFFFFFFF.
- Boundary codes:
  - code=0 → `done` next cycle, `out`=0, `err`=0.
  - code=33 → `out`=0, `err`=1, latency 1.
  - code=0xFFFFFFFF → `err`=1.
- Busy protection and back-to-back:
  - code=10 start, then start code=3 plus `mode` toggle at cycle 4 → result is 0x00000200 at cycle 10 in one-hot.
  - Start code=2 held high in the `done` cycle → next `done` 2 cycles later with `out`=0x2.
- Round-trip: random code 0..32 → feed `out` to the DIFF encoder → encoder output equals `code`.

Source files
------------

// File: rtl/pos_decode_pkg.sv
// Shared definitions for the bit-position decode coprocessor.
package pos_decode_pkg;

    localparam int unsigned CODE_W   = 32;
    localparam int unsigned POS_NONE = 0;
    localparam int unsigned POS_MAX  = 32;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/pos_shift_mask.sv
// Mask shift register: loads a single 1 in bit 0, then shifts left with a chosen fill bit.
module pos_shift_mask #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_mask
);

    logic [WIDTH-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (i_load) begin
            r_mask <= WIDTH'(1);
        end else if (i_shift) begin
            r_mask <= {r_mask[WIDTH-2:0], i_fill};
        end
    end

    assign o_mask = r_mask;

endmodule

// File: rtl/pos_decode_unit.sv
// Start/done coprocessor turning a bit-position code into a one-hot or thermometer mask,
// building the mask one shift per cycle.
module pos_decode_unit
    import pos_decode_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  out
);

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_mode;
    logic             w_next_mode;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next_out;
    logic             r_err;
    logic             w_next_err;
    logic             r_done;
    logic             w_next_done;
    logic             r_busy;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_mask;
    logic [CNT_W-1:0] w_code_lo;

    // Range check looks at the full code; only the low bits feed the counter.
    assign w_code_lo = code[CNT_W-1:0];

    pos_shift_mask #(
        .WIDTH (WIDTH)
    ) u_shift_mask (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_fill  (r_mode == MODE_THERMO),
        .o_mask  (w_mask)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_mode  = r_mode;
        w_next_out   = r_out;
        w_next_err   = r_err;
        w_next_done  = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_out = '0;
                    w_next_err = 1'b0;
                    if (code == CODE_W'(POS_NONE)) begin
                        w_next_done = 1'b1;
                    end else if (code > CODE_W'(WIDTH)) begin
                        w_next_err  = 1'b1;
                        w_next_done = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_next_cnt   = w_code_lo - CNT_W'(1);
                        w_next_mode  = mode;
                        w_next_state = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_next_out   = w_mask;
                    w_next_done  = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_shift    = 1'b1;
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_ONEHOT;
            r_out   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_mode  <= w_next_mode;
            r_out   <= w_next_out;
            r_err   <= w_next_err;
            r_done  <= w_next_done;
            r_busy  <= (w_next_state == S_SHIFT);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign out  = r_out;

endmodule
